radiation_pulse_processor: RTL and testbench
============================================

Name: radiation_pulse_processor

Overview:
- Upstream neighbour of the hardware-accelerated histogram, part of the RadiationProcessor group.
- Accepts a stream of digitised detector samples, subtracts a programmable baseline and detects pulses above a programmable threshold.
- Tracks each pulse's peak and emits one 10-bit pulse-height value per accepted pulse on valueReady/radiationValue.
- Enforces the event spacing the histogram's 3-cycle read-modify-write needs. Keeps accepted/rejected pulse counters for software.

Parameters:
- ADC_WIDTH, 12, sample width in bits; must be ≥ 10.
- MIN_PULSE_LEN, 2, minimum accepted samples above threshold; shorter pulses are rejected as noise.
- MAX_PULSE_LEN, 64, pulse length at which the pulse is rejected as pile-up.
- READY_CYCLES, 4, clocks valueReady is held high per event.
- HOLDOFF_CYCLES, 4, dead-time clocks after valueReady falls (or after a pile-up reject); must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  processing enable (software register)
- sampleValid  in  1  adcSample is valid this cycle
- adcSample  in  ADC_WIDTH  raw ADC sample, unsigned
- baseline  in  ADC_WIDTH  baseline subtracted from each sample (software register)
- threshold  in  ADC_WIDTH  trigger level applied to the baseline-corrected sample (software register)
- clearCounters  in  1  single-cycle pulse; zeroes both counters
- valueReady  out  1  event strobe, high for READY_CYCLES
- radiationValue  out  10  pulse height of the latest event
- pulseCount  out  16  accepted pulses, saturating
- rejectCount  out  16  rejected pulses (short, pile-up), saturating
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset is low, all outputs and registers are 0 and the state is IDLE.
- diff = adcSample − baseline when adcSample > baseline, else 0. Width is ADC_WIDTH and diff never underflows.
- States: IDLE, PEAK, READY, HOLDOFF.
- IDLE:
  - When sampleValid && enable && diff > threshold: go to PEAK with peak ← diff and len ← 1.
  - Otherwise stay in IDLE.
- PEAK, evaluated on each sampleValid cycle (cycles without sampleValid hold all state):
  - If diff > threshold: peak ← max(peak, diff) and len ← len+1.
    - If len+1 == MAX_PULSE_LEN: rejectCount++ and go to HOLDOFF. No event is emitted.
  - If diff ≤ threshold and len ≥ MIN_PULSE_LEN: emit and go to READY.
  - If diff ≤ threshold and len < MIN_PULSE_LEN: rejectCount++ and go to IDLE.
  - If enable drops: abort to IDLE. No event, no count change.
- Emit: on the same edge, radiationValue ← peak >> (ADC_WIDTH−10), valueReady ← 1 and pulseCount++.
  - Latency: outputs change one clock after the terminating sample is accepted.
- READY:
  - valueReady stays high for exactly READY_CYCLES clocks, then drops and the FSM goes to HOLDOFF.
  - radiationValue is stable from the rising edge of valueReady until the next emit.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES clocks, ignoring all samples, then goes to IDLE.
  - READY and HOLDOFF always complete even if enable drops.
- Event spacing: rising edges of valueReady are at least READY_CYCLES+HOLDOFF_CYCLES+2 clocks apart, which is never less than 4.
- Counters:
  - Both saturate at 0xFFFF.
  - clearCounters takes priority over an increment in the same cycle; the result is 0.
- Changes to baseline or threshold mid-pulse take effect on the next sample. No re-arm is needed.

Decomposition:
- Shared package radiation_pkg holds:
  - the state enumeration (IDLE, PEAK, READY, HOLDOFF),
  - RADIATION_VALUE_WIDTH = 10,
  - COUNTER_WIDTH = 16.
- One sub-module, saturating_counter (COUNTER_WIDTH wide, with inc and clr inputs), instantiated twice for pulseCount and rejectCount.

Test Plan (ADC_WIDTH=12, baseline=100, threshold=50, defaults otherwise):
- Pulse 100,200,900,2148,1500,120 on consecutive sampleValid cycles → peak diff 2048. One clock after sample 120: radiationValue=512, valueReady high 4 cycles, pulseCount=1, busy high until HOLDOFF ends.
- Short pulse 100,300,100 (len 1) → no valueReady, rejectCount=1, returns to IDLE next clock.
- 70 consecutive samples of 1000 → rejectCount=1 at the 64th above-threshold sample. No valueReady; samples ignored during HOLDOFF.
- Two back-to-back valid pulses with no gap → second pulse's samples ignored until IDLE. Rising edges of valueReady ≥ 10 clocks apart.
- Reset asserted mid-PEAK and mid-READY → valueReady=0, radiationValue=0, counters=0, state IDLE immediately (asynchronous).
- sampleValid toggling every other cycle during a pulse, and clearCounters coincident with an emit → peak unaffected by invalid cycles; pulseCount=0 after the coincident cycle.

Source files
------------

// File: rtl/radiation_pulse_processor_pkg.sv
// Shared types and widths for the radiation pulse processing chain.
package radiation_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEAK    = 2'd1,
        READY   = 2'd2,
        HOLDOFF = 2'd3
    } radState_t;

    localparam int unsigned RADIATION_VALUE_WIDTH = 10;
    localparam int unsigned COUNTER_WIDTH         = 16;

endpackage

// File: rtl/radiation_pulse_processor_counter.sv
// Saturating up-counter; clear wins over increment.
module saturating_counter
    import radiation_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/radiation_pulse_processor.sv
// Baseline-corrected pulse detector: peak capture, event strobe and dead-time for the histogram.
module radiation_pulse_processor
    import radiation_pkg::*;
#(
    parameter int unsigned ADC_WIDTH      = 12,
    parameter int unsigned MIN_PULSE_LEN  = 2,
    parameter int unsigned MAX_PULSE_LEN  = 64,
    parameter int unsigned READY_CYCLES   = 4,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             sampleValid,
    input  logic [ADC_WIDTH-1:0]             adcSample,
    input  logic [ADC_WIDTH-1:0]             baseline,
    input  logic [ADC_WIDTH-1:0]             threshold,
    input  logic                             clearCounters,
    output logic                             valueReady,
    output logic [RADIATION_VALUE_WIDTH-1:0] radiationValue,
    output logic [COUNTER_WIDTH-1:0]         pulseCount,
    output logic [COUNTER_WIDTH-1:0]         rejectCount,
    output logic                             busy
);

    localparam int unsigned LEN_W   = $clog2(MAX_PULSE_LEN + 1);
    localparam int unsigned MAX_TMR = (READY_CYCLES > HOLDOFF_CYCLES) ? READY_CYCLES : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W   = (MAX_TMR < 2) ? 1 : $clog2(MAX_TMR);

    radState_t                        state, stateNext;
    logic [ADC_WIDTH-1:0]             peak, peakNext;
    logic [LEN_W-1:0]                 len, lenNext, lenInc;
    logic [TMR_W-1:0]                 timer, timerNext;
    logic [RADIATION_VALUE_WIDTH-1:0] valueNext;
    logic [ADC_WIDTH-1:0]             diff;
    logic                             above;
    logic                             pulseInc;
    logic                             rejectInc;

    assign diff   = (adcSample > baseline) ? (adcSample - baseline) : '0;
    assign above  = (diff > threshold);
    assign lenInc = LEN_W'(len + 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            peak           <= '0;
            len            <= '0;
            timer          <= '0;
            radiationValue <= '0;
        end else begin
            state          <= stateNext;
            peak           <= peakNext;
            len            <= lenNext;
            timer          <= timerNext;
            radiationValue <= valueNext;
        end
    end

    always_comb begin
        stateNext = state;
        peakNext  = peak;
        lenNext   = len;
        timerNext = timer;
        valueNext = radiationValue;
        pulseInc  = 1'b0;
        rejectInc = 1'b0;
        case (state)
            IDLE: begin
                if (sampleValid && enable && above) begin
                    stateNext = PEAK;
                    peakNext  = diff;
                    lenNext   = LEN_W'(1);
                end
            end
            PEAK: begin
                // Disable aborts silently; cycles without sampleValid leave the pulse untouched.
                if (!enable) begin
                    stateNext = IDLE;
                end else if (sampleValid) begin
                    if (above) begin
                        peakNext = (diff > peak) ? diff : peak;
                        lenNext  = lenInc;
                        if (lenInc == LEN_W'(MAX_PULSE_LEN)) begin
                            rejectInc = 1'b1;
                            stateNext = HOLDOFF;
                            timerNext = '0;
                        end
                    end else if (len >= LEN_W'(MIN_PULSE_LEN)) begin
                        valueNext = peak[ADC_WIDTH-1 -: RADIATION_VALUE_WIDTH];
                        pulseInc  = 1'b1;
                        stateNext = READY;
                        timerNext = '0;
                    end else begin
                        rejectInc = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            READY: begin
                if (timer == TMR_W'(READY_CYCLES - 1)) begin
                    stateNext = HOLDOFF;
                    timerNext = '0;
                end else begin
                    timerNext = TMR_W'(timer + 1'b1);
                end
            end
            HOLDOFF: begin
                if (timer == TMR_W'(HOLDOFF_CYCLES - 1)) begin
                    stateNext = IDLE;
                    timerNext = '0;
                end else begin
                    timerNext = TMR_W'(timer + 1'b1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign valueReady = (state == READY);
    assign busy       = (state != IDLE);

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) pulseCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (pulseInc),
        .clr   (clearCounters),
        .count (pulseCount)
    );

    saturating_counter #(.WIDTH(COUNTER_WIDTH)) rejectCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (rejectInc),
        .clr   (clearCounters),
        .count (rejectCount)
    );

endmodule

// File: tb/tb_radiation_pulse_processor.sv
// Directed vector bench for radiation_pulse_processor (ADC_WIDTH=12, baseline 100, threshold 50).
module tb_radiation_pulse_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sampleValid;
    logic [11:0] adcSample;
    logic [11:0] baseline;
    logic [11:0] threshold;
    logic        clearCounters;
    logic        valueReady;
    logic [9:0]  radiationValue;
    logic [15:0] pulseCount;
    logic [15:0] rejectCount;
    logic        busy;

    logic        cInc;
    logic        cClr;
    logic [3:0]  cCount;

    int unsigned nVectors = 0;
    int unsigned nMiscompares = 0;

    typedef struct {
        logic        sv;
        logic [11:0] adc;
        logic        expReady;
        logic [9:0]  expValue;
        logic [15:0] expPulse;
        logic [15:0] expReject;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    radiation_pulse_processor #(
        .ADC_WIDTH      (12),
        .MIN_PULSE_LEN  (2),
        .MAX_PULSE_LEN  (64),
        .READY_CYCLES   (4),
        .HOLDOFF_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sampleValid    (sampleValid),
        .adcSample      (adcSample),
        .baseline       (baseline),
        .threshold      (threshold),
        .clearCounters  (clearCounters),
        .valueReady     (valueReady),
        .radiationValue (radiationValue),
        .pulseCount     (pulseCount),
        .rejectCount    (rejectCount),
        .busy           (busy)
    );

    saturating_counter #(.WIDTH(4)) satC (
        .clk   (clk),
        .reset (reset),
        .inc   (cInc),
        .clr   (cClr),
        .count (cCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic r, input logic [9:0] v,
                            input logic [15:0] pc, input logic [15:0] rc, input logic b);
        check({tag, " valueReady"}, 32'(valueReady), 32'(r));
        check({tag, " radiationValue"}, 32'(radiationValue), 32'(v));
        check({tag, " pulseCount"}, 32'(pulseCount), 32'(pc));
        check({tag, " rejectCount"}, 32'(rejectCount), 32'(rc));
        check({tag, " busy"}, 32'(busy), 32'(b));
    endtask

    task automatic addVec(input logic sv, input logic [11:0] adc, input logic r, input logic [9:0] v,
                          input logic [15:0] pc, input logic [15:0] rc, input logic b);
        vec_t t;
        t.sv = sv; t.adc = adc; t.expReady = r; t.expValue = v;
        t.expPulse = pc; t.expReject = rc; t.expBusy = b;
        vecs.push_back(t);
    endtask

    task automatic pulseOnce(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        sampleValid = 1'b1;
        adcSample = a; tick();
        adcSample = b; tick();
        adcSample = c; tick();
        sampleValid = 1'b0;
    endtask

    initial begin
        int rises[$];
        logic prevReady;
        logic [11:0] pat [3];

        reset = 1'b0; enable = 1'b0; sampleValid = 1'b0; adcSample = '0;
        baseline = 12'd100; threshold = 12'd50; clearCounters = 1'b0;
        cInc = 1'b0; cClr = 1'b0;
        #1;
        checkAll("reset", 1'b0, 10'd0, 16'd0, 16'd0, 1'b0);
        tick(); tick();
        reset = 1'b1; enable = 1'b1;

        // Main pulse: peak diff 2048 -> 512, then READY x4, HOLDOFF x4, then a short pulse.
        addVec(1, 12'd100,  0, 10'd0,   1'd0, 0, 0);
        addVec(1, 12'd200,  0, 10'd0,   0, 0, 1);
        addVec(1, 12'd900,  0, 10'd0,   0, 0, 1);
        addVec(1, 12'd2148, 0, 10'd0,   0, 0, 1);
        addVec(1, 12'd1500, 0, 10'd0,   0, 0, 1);
        addVec(1, 12'd120,  1, 10'd512, 1, 0, 1);
        for (int i = 0; i < 3; i++) addVec(0, 12'd0, 1, 10'd512, 1, 0, 1);
        for (int i = 0; i < 4; i++) addVec(1, 12'd3000, 0, 10'd512, 1, 0, 1);
        addVec(0, 12'd0,    0, 10'd512, 1, 0, 0);
        addVec(1, 12'd100,  0, 10'd512, 1, 0, 0);
        addVec(1, 12'd300,  0, 10'd512, 1, 0, 1);
        addVec(1, 12'd100,  0, 10'd512, 1, 1, 0);
        addVec(0, 12'd0,    0, 10'd512, 1, 1, 0);

        foreach (vecs[i]) begin
            sampleValid = vecs[i].sv;
            adcSample   = vecs[i].adc;
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValue,
                     vecs[i].expPulse, vecs[i].expReject, vecs[i].expBusy);
        end

        // Pile-up: 70 samples of 1000, reject at the 64th, HOLDOFF swallows 65..68.
        clearCounters = 1'b1; tick(); clearCounters = 1'b0;
        check("clear pulseCount", 32'(pulseCount), 32'd0);
        check("clear rejectCount", 32'(rejectCount), 32'd0);
        sampleValid = 1'b1; adcSample = 12'd1000;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (valueReady !== 1'b0) check($sformatf("pileup ready@%0d", i), 32'(valueReady), 32'd0);
            if (i == 63) check("pileup rc@63", 32'(rejectCount), 32'd0);
            if (i == 64) begin
                check("pileup rc@64", 32'(rejectCount), 32'd1);
                check("pileup busy@64", 32'(busy), 32'd1);
            end
            if (i == 67) check("pileup holdoff busy@67", 32'(busy), 32'd1);
            if (i == 68) check("pileup idle@68", 32'(busy), 32'd0);
            if (i == 69) check("pileup repeak@69", 32'(busy), 32'd1);
        end
        sampleValid = 1'b0; enable = 1'b0; tick();
        checkAll("abort", 1'b0, 10'd512, 16'd0, 16'd1, 1'b0);
        enable = 1'b1;

        // Back-to-back pulses with no gap: rising edges expected at cycles 2, 14, 26.
        clearCounters = 1'b1; tick(); clearCounters = 1'b0;
        pat[0] = 12'd300; pat[1] = 12'd400; pat[2] = 12'd100;
        prevReady = valueReady;
        sampleValid = 1'b1;
        for (int k = 0; k < 36; k++) begin
            adcSample = pat[k % 3];
            tick();
            if (valueReady && !prevReady) rises.push_back(k);
            prevReady = valueReady;
        end
        sampleValid = 1'b0;
        check("b2b emits", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("b2b rise0", 32'(rises[0]), 32'd2);
            check("b2b rise1", 32'(rises[1]), 32'd14);
            check("b2b rise2", 32'(rises[2]), 32'd26);
        end
        check("b2b pulseCount", 32'(pulseCount), 32'd3);
        check("b2b value", 32'(radiationValue), 32'd75);

        // Asynchronous reset mid-PEAK.
        sampleValid = 1'b1; adcSample = 12'd300; tick(); sampleValid = 1'b0;
        check("prePeak busy", 32'(busy), 32'd1);
        reset = 1'b0; #2;
        checkAll("rstPeak", 1'b0, 10'd0, 16'd0, 16'd0, 1'b0);
        #1 reset = 1'b1;

        // Asynchronous reset mid-READY.
        pulseOnce(12'd300, 12'd400, 12'd100);
        tick();
        check("preReady ready", 32'(valueReady), 32'd1);
        reset = 1'b0; #2;
        checkAll("rstReady", 1'b0, 10'd0, 16'd0, 16'd0, 1'b0);
        #1 reset = 1'b1;
        tick();

        // Gapped sampleValid with large invalid samples; clear coincident with the emit.
        sampleValid = 1'b1; adcSample = 12'd300;  tick();
        sampleValid = 1'b0; adcSample = 12'd4000; tick();
        sampleValid = 1'b1; adcSample = 12'd350;  tick();
        sampleValid = 1'b0; adcSample = 12'd4095; tick();
        check("gap busy", 32'(busy), 32'd1);
        sampleValid = 1'b1; adcSample = 12'd100; clearCounters = 1'b1; tick();
        sampleValid = 1'b0; clearCounters = 1'b0;
        checkAll("gapEmit", 1'b1, 10'd62, 16'd0, 16'd0, 1'b1);
        tick();
        check("gapAfter pulseCount", 32'(pulseCount), 32'd0);

        // Standalone 4-bit counter saturation and clear priority.
        cInc = 1'b1;
        repeat (20) tick();
        check("sat count", 32'(cCount), 32'd15);
        cClr = 1'b1; tick();
        check("sat clr+inc", 32'(cCount), 32'd0);
        cClr = 1'b0; tick();
        check("sat resume", 32'(cCount), 32'd1);
        cInc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
